// File: rtl/ad9866_pkg.sv
// Shared constants, register map and FSM encoding for the AD9866 serial-port responder.
package ad9866_pkg;

  localparam int NUM_REGS       = 20;
  localparam int MIN_OVERSAMPLE = 4;

  localparam logic [4:0] REG_COUNT    = 5'd20;
  localparam logic [4:0] ADDR_SPI_CFG = 5'h00;
  localparam logic [4:0] ADDR_RX_CTRL = 5'h07;
  localparam logic [4:0] ADDR_RX_GAIN = 5'h09;
  localparam logic [4:0] ADDR_TX_GAIN = 5'h0a;
  localparam logic [4:0] CAL_CYCLES   = 5'd16;

  localparam logic [7:0] REG_RESET [NUM_REGS] = '{default: 8'h00};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_DATA_W = 3'd2,
    ST_DATA_R = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // A frame targets a real register only with length 00 and an implemented address.
  function automatic logic addr_ok(input logic [4:0] addr, input logic [1:0] len);
    return (len == 2'b00) && (addr < REG_COUNT);
  endfunction

endpackage

// File: rtl/ad9866_spi_sync.sv
// Input conditioning for the SPI pins: register (or 2-flop synchronize when
// AD9866_SPI_SYNC_EN is defined) and produce sclk edge pulses.
module ad9866_spi_sync (
  input  logic clk,
  input  logic reset,
  input  logic sclk,
  input  logic sen_n,
  input  logic sdio,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic sen_n_lvl,
  output logic sdio_lvl
);

  logic sclk_in_s;
  logic sen_n_in_s;
  logic sdio_in_s;
  logic sclk_stg_r;
  logic sclk_prev_r;
  logic sen_n_stg_r;
  logic sdio_stg_r;

`ifdef AD9866_SPI_SYNC_EN
  logic [1:0] sync_sclk_r;
  logic [1:0] sync_sen_n_r;
  logic [1:0] sync_sdio_r;

  // Two-flop synchronizers for a master in an unrelated clock domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_sclk_r  <= 2'b00;
      sync_sen_n_r <= 2'b11;
      sync_sdio_r  <= 2'b00;
    end else begin
      sync_sclk_r  <= {sync_sclk_r[0], sclk};
      sync_sen_n_r <= {sync_sen_n_r[0], sen_n};
      sync_sdio_r  <= {sync_sdio_r[0], sdio};
    end
  end

  assign sclk_in_s  = sync_sclk_r[1];
  assign sen_n_in_s = sync_sen_n_r[1];
  assign sdio_in_s  = sync_sdio_r[1];
`else
  assign sclk_in_s  = sclk;
  assign sen_n_in_s = sen_n;
  assign sdio_in_s  = sdio;
`endif

  // Common register stage plus the delayed sclk copy used for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_stg_r  <= 1'b0;
      sclk_prev_r <= 1'b0;
      sen_n_stg_r <= 1'b1;
      sdio_stg_r  <= 1'b0;
    end else begin
      sclk_stg_r  <= sclk_in_s;
      sclk_prev_r <= sclk_stg_r;
      sen_n_stg_r <= sen_n_in_s;
      sdio_stg_r  <= sdio_in_s;
    end
  end

  assign sclk_rise = sclk_stg_r & ~sclk_prev_r;
  assign sclk_fall = ~sclk_stg_r & sclk_prev_r;
  assign sen_n_lvl = sen_n_stg_r;
  assign sdio_lvl  = sdio_stg_r;

endmodule

// File: rtl/ad9866_spi_responder.sv
// AD9866 serial control port model: 16-bit frame decode, 20-entry register file,
// read-back on sdo and a write-event stream. Optional macro: AD9866_SPI_SYNC_EN.
module ad9866_spi_responder (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       sen_n,
  input  logic       sdio,
  output logic       sdo,
  output logic       sdo_oe,
  output logic [5:0] rx_gain,
  output logic [5:0] tx_gain,
  output logic       four_wire,
  output logic       wr_strobe,
  output logic [4:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_abort
);
  import ad9866_pkg::*;

  logic        sclk_rise_s;
  logic        sclk_fall_s;
  logic        sen_n_s;
  logic        sdio_s;
  state_t      state_r;
  state_t      state_nxt_s;
  logic [15:0] shift_r;
  logic [15:0] shift_nxt_s;
  logic [4:0]  bit_cnt_r;
  logic [7:0]  regs_r [NUM_REGS];
  logic [7:0]  rd_buf_r;
  logic [7:0]  rd_val_s;
  logic [4:0]  cal_cnt_r;
  logic        hdr_done_s;
  logic        frame_end_s;
  logic        abort_s;
  logic        commit_s;
  logic        rd_load_s;
  logic        four_wire_s;
  logic [4:0]  wr_addr_s;
  logic [7:0]  wr_data_s;
  logic        sdo_r;
  logic        sdo_oe_r;
  logic        wr_strobe_r;
  logic [4:0]  wr_addr_r;
  logic [7:0]  wr_data_r;
  logic        frame_abort_r;

  ad9866_spi_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .sclk      (sclk),
    .sen_n     (sen_n),
    .sdio      (sdio),
    .sclk_rise (sclk_rise_s),
    .sclk_fall (sclk_fall_s),
    .sen_n_lvl (sen_n_s),
    .sdio_lvl  (sdio_s)
  );

  // The shift value including the bit arriving this cycle lets decode happen on the edge itself.
  assign shift_nxt_s = {shift_r[14:0], sdio_s};
  assign hdr_done_s  = sclk_rise_s && (bit_cnt_r == 5'd7);
  assign frame_end_s = sclk_rise_s && (bit_cnt_r == 5'd15);
  assign four_wire_s = regs_r[ADDR_SPI_CFG][7];
  assign wr_addr_s   = shift_nxt_s[12:8];
  assign wr_data_s   = shift_nxt_s[7:0];

  // Frame FSM next state and event decode; a completed frame wins over a late sen_n rise.
  always_comb begin
    state_nxt_s = state_r;
    abort_s     = 1'b0;
    commit_s    = 1'b0;
    rd_load_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!sen_n_s) state_nxt_s = ST_HDR;
        else          state_nxt_s = ST_IDLE;
      end
      ST_HDR: begin
        if (hdr_done_s) begin
          state_nxt_s = shift_nxt_s[7] ? ST_DATA_R : ST_DATA_W;
          rd_load_s   = shift_nxt_s[7];
        end else if (sen_n_s) begin
          state_nxt_s = ST_IDLE;
          abort_s     = 1'b1;
        end else begin
          state_nxt_s = ST_HDR;
        end
      end
      ST_DATA_W, ST_DATA_R: begin
        if (frame_end_s) begin
          state_nxt_s = ST_DONE;
          commit_s    = (state_r == ST_DATA_W) && addr_ok(shift_nxt_s[12:8], shift_nxt_s[14:13]);
        end else if (sen_n_s) begin
          state_nxt_s = ST_IDLE;
          abort_s     = 1'b1;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_DONE: begin
        if (sen_n_s) state_nxt_s = ST_IDLE;
        else         state_nxt_s = ST_DONE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Read value snapshot taken from the header just completed.
  always_comb begin
    rd_val_s = 8'h00;
    if (addr_ok(shift_nxt_s[4:0], shift_nxt_s[6:5])) rd_val_s = regs_r[shift_nxt_s[4:0]];
    else                                              rd_val_s = 8'h00;
  end

  // Frame state, bit counter, shifter and registered event/sdo outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      shift_r       <= 16'h0000;
      bit_cnt_r     <= 5'd0;
      rd_buf_r      <= 8'h00;
      sdo_r         <= 1'b0;
      sdo_oe_r      <= 1'b0;
      wr_strobe_r   <= 1'b0;
      wr_addr_r     <= 5'd0;
      wr_data_r     <= 8'h00;
      frame_abort_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (sen_n_s)          bit_cnt_r <= 5'd0;
      else if (sclk_rise_s) bit_cnt_r <= bit_cnt_r + 5'd1;
      if (sclk_rise_s) shift_r <= shift_nxt_s;
      frame_abort_r <= abort_s;
      wr_strobe_r   <= commit_s;
      if (commit_s) begin
        wr_addr_r <= wr_addr_s;
        wr_data_r <= wr_data_s;
      end
      if (rd_load_s) begin
        rd_buf_r <= rd_val_s;
        sdo_r    <= four_wire_s & rd_val_s[7];
      end else if (state_nxt_s != ST_DATA_R) begin
        sdo_r <= 1'b0;
      end else if (sclk_fall_s) begin
        rd_buf_r <= {rd_buf_r[6:0], 1'b0};
        sdo_r    <= four_wire_s & rd_buf_r[6];
      end
      sdo_oe_r <= four_wire_s && (state_nxt_s == ST_DATA_R);
    end
  end

  // Register file with the self-clearing DC-offset calibration start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= REG_RESET[i];
      cal_cnt_r <= 5'd0;
    end else begin
      if (commit_s) regs_r[wr_addr_s] <= wr_data_s;
      if (commit_s && (wr_addr_s == ADDR_RX_CTRL)) begin
        cal_cnt_r <= wr_data_s[0] ? CAL_CYCLES : 5'd0;
      end else if (cal_cnt_r != 5'd0) begin
        cal_cnt_r <= cal_cnt_r - 5'd1;
        if (cal_cnt_r == 5'd1) regs_r[ADDR_RX_CTRL][0] <= 1'b0;
      end
    end
  end

  assign sdo         = sdo_r;
  assign sdo_oe      = sdo_oe_r;
  assign rx_gain     = regs_r[ADDR_RX_GAIN][5:0];
  assign tx_gain     = regs_r[ADDR_TX_GAIN][5:0];
  assign four_wire   = four_wire_s;
  assign wr_strobe   = wr_strobe_r;
  assign wr_addr     = wr_addr_r;
  assign wr_data     = wr_data_r;
  assign frame_abort = frame_abort_r;

endmodule

// File: tb/tb_ad9866_spi_responder.sv
// Directed bench for ad9866_spi_responder: table of full frames plus hand-written
// sequences for abort, calibration self-clear, reset mid-frame and late sen_n.
module tb_ad9866_spi_responder;

  localparam int HALF = 4;

  logic       clk;
  logic       reset;
  logic       sclk;
  logic       sen_n;
  logic       sdio;
  logic       sdo;
  logic       sdo_oe;
  logic [5:0] rx_gain;
  logic [5:0] tx_gain;
  logic       four_wire;
  logic       wr_strobe;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_abort;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  int abort_cnt = 0;
  int oe_cnt = 0;

  ad9866_spi_responder dut (
    .clk         (clk),
    .reset       (reset),
    .sclk        (sclk),
    .sen_n       (sen_n),
    .sdio        (sdio),
    .sdo         (sdo),
    .sdo_oe      (sdo_oe),
    .rx_gain     (rx_gain),
    .tx_gain     (tx_gain),
    .four_wire   (four_wire),
    .wr_strobe   (wr_strobe),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .frame_abort (frame_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe)   strobe_cnt <= strobe_cnt + 1;
    if (frame_abort) abort_cnt  <= abort_cnt + 1;
    if (sdo_oe)      oe_cnt     <= oe_cnt + 1;
  end

  typedef struct {
    logic [15:0] frame;
    logic [7:0]  exp_sdo;
    int          exp_strobes;
    int          exp_oe;
    logic [4:0]  exp_wa;
    logic [7:0]  exp_wd;
    logic [5:0]  exp_rx;
    logic [5:0]  exp_tx;
    logic        exp_fw;
  } vec_t;

  vec_t vecs [13];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Read bit7 is sampled late in the 8th high phase, the rest late in low phases 8..14.
  task automatic drive_bits(input logic [15:0] word, input int nbits, output logic [7:0] rd);
    rd = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      sdio = word[15-i];
      sclk = 1'b0;
      tick(HALF);
      if (i >= 8 && i <= 14) rd[14-i] = sdo;
      sclk = 1'b1;
      tick(HALF);
      if (i == 7) rd[7] = sdo;
    end
  endtask

  task automatic run_frame(input logic [15:0] word, output logic [7:0] rd);
    sen_n = 1'b0;
    tick(HALF);
    drive_bits(word, 16, rd);
    sclk = 1'b0;
    tick(HALF);
    sen_n = 1'b1;
    tick(2 * HALF);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    sclk  = 1'b0;
    sen_n = 1'b1;
    sdio  = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(2);
  endtask

  initial begin
    logic [7:0] rd;
    int s0, a0, o0;
    logic found;

    vecs[0]  = '{16'h0080, 8'h00, 1, 0,  5'h00, 8'h80, 6'h00, 6'h00, 1'b1};
    vecs[1]  = '{16'h0945, 8'h00, 1, 0,  5'h09, 8'h45, 6'h05, 6'h00, 1'b1};
    vecs[2]  = '{16'h8900, 8'h45, 0, 64, 5'h09, 8'h45, 6'h05, 6'h00, 1'b1};
    vecs[3]  = '{16'h9400, 8'h00, 0, 64, 5'h09, 8'h45, 6'h05, 6'h00, 1'b1};
    vecs[4]  = '{16'h0a3c, 8'h00, 1, 0,  5'h0a, 8'h3c, 6'h05, 6'h3c, 1'b1};
    vecs[5]  = '{16'h8a00, 8'h3c, 0, 64, 5'h0a, 8'h3c, 6'h05, 6'h3c, 1'b1};
    vecs[6]  = '{16'h2a11, 8'h00, 0, 0,  5'h0a, 8'h3c, 6'h05, 6'h3c, 1'b1};
    vecs[7]  = '{16'h1f55, 8'h00, 0, 0,  5'h0a, 8'h3c, 6'h05, 6'h3c, 1'b1};
    vecs[8]  = '{16'ha900, 8'h00, 0, 64, 5'h0a, 8'h3c, 6'h05, 6'h3c, 1'b1};
    vecs[9]  = '{16'h0900, 8'h00, 1, 0,  5'h09, 8'h00, 6'h00, 6'h3c, 1'b1};
    vecs[10] = '{16'h0000, 8'h00, 1, 0,  5'h00, 8'h00, 6'h00, 6'h3c, 1'b0};
    vecs[11] = '{16'h8a00, 8'h00, 0, 0,  5'h00, 8'h00, 6'h00, 6'h3c, 1'b0};
    vecs[12] = '{16'h0080, 8'h00, 1, 0,  5'h00, 8'h80, 6'h00, 6'h3c, 1'b1};

    pulse_reset();
    check("rst_sdo",       32'(sdo), 32'h0);
    check("rst_sdo_oe",    32'(sdo_oe), 32'h0);
    check("rst_rx_gain",   32'(rx_gain), 32'h0);
    check("rst_tx_gain",   32'(tx_gain), 32'h0);
    check("rst_four_wire", 32'(four_wire), 32'h0);
    check("rst_wr_strobe", 32'(wr_strobe), 32'h0);
    check("rst_wr_addr",   32'(wr_addr), 32'h0);
    check("rst_wr_data",   32'(wr_data), 32'h0);
    check("rst_abort",     32'(frame_abort), 32'h0);

    for (int v = 0; v < 13; v++) begin
      s0 = strobe_cnt;
      o0 = oe_cnt;
      a0 = abort_cnt;
      run_frame(vecs[v].frame, rd);
      $display("vector %0d frame %h", v, vecs[v].frame);
      check("vec_sdo",     32'(rd), 32'(vecs[v].exp_sdo));
      check("vec_strobes", 32'(strobe_cnt - s0), 32'(vecs[v].exp_strobes));
      check("vec_oe_cyc",  32'(oe_cnt - o0), 32'(vecs[v].exp_oe));
      check("vec_abort",   32'(abort_cnt - a0), 32'h0);
      check("vec_wr_addr", 32'(wr_addr), 32'(vecs[v].exp_wa));
      check("vec_wr_data", 32'(wr_data), 32'(vecs[v].exp_wd));
      check("vec_rx_gain", 32'(rx_gain), 32'(vecs[v].exp_rx));
      check("vec_tx_gain", 32'(tx_gain), 32'(vecs[v].exp_tx));
      check("vec_fw",      32'(four_wire), 32'(vecs[v].exp_fw));
      check("vec_idle_sdo", 32'({sdo, sdo_oe}), 32'h0);
    end

    // Truncated write after 10 bits.
    pulse_reset();
    s0 = strobe_cnt;
    a0 = abort_cnt;
    sen_n = 1'b0;
    tick(HALF);
    drive_bits(16'h0a3f, 10, rd);
    sclk = 1'b0;
    tick(HALF);
    sen_n = 1'b1;
    tick(2 * HALF);
    check("abort_pulse",   32'(abort_cnt - a0), 32'h1);
    check("abort_nowrite", 32'(strobe_cnt - s0), 32'h0);
    check("abort_tx_gain", 32'(tx_gain), 32'h0);
    run_frame(16'h0a3f, rd);
    check("post_abort_tx", 32'(tx_gain), 32'h3f);

    // Calibration start bit self-clears 16 clk after the commit.
    sen_n = 1'b0;
    tick(HALF);
    drive_bits(16'h0721, 15, rd);
    sdio = 1'b1;
    sclk = 1'b0;
    tick(HALF);
    sclk = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      tick(1);
      if (wr_strobe) found = 1'b1;
    end
    check("cal_strobe",  32'(found), 32'h1);
    check("cal_written", 32'(dut.regs_r[7]), 32'h21);
    tick(15);
    check("cal_hold_15", 32'(dut.regs_r[7]), 32'h21);
    tick(1);
    check("cal_clear_16", 32'(dut.regs_r[7]), 32'h20);
    sclk = 1'b0;
    tick(HALF);
    sen_n = 1'b1;
    tick(2 * HALF);
    run_frame(16'h0080, rd);
    run_frame(16'h8700, rd);
    check("cal_readback", 32'(rd), 32'h20);

    // Reset in the middle of a tx_gain write.
    sen_n = 1'b0;
    tick(HALF);
    a0 = abort_cnt;
    drive_bits(16'h0a12, 12, rd);
    pulse_reset();
    check("midrst_tx",    32'(tx_gain), 32'h0);
    check("midrst_fw",    32'(four_wire), 32'h0);
    check("midrst_abort", 32'(abort_cnt - a0), 32'h0);
    check("midrst_wdata", 32'(wr_data), 32'h0);
    run_frame(16'h0a12, rd);
    check("postrst_tx",   32'(tx_gain), 32'h12);
    check("postrst_wa",   32'(wr_addr), 32'h0a);

    // sen_n rises together with the 16th sclk rise: commit, no abort.
    s0 = strobe_cnt;
    a0 = abort_cnt;
    sen_n = 1'b0;
    tick(HALF);
    drive_bits(16'h0a2b, 15, rd);
    sdio = 1'b1;
    sclk = 1'b0;
    tick(HALF);
    sclk  = 1'b1;
    sen_n = 1'b1;
    tick(2 * HALF);
    sclk = 1'b0;
    tick(2 * HALF);
    check("late_sen_strobe", 32'(strobe_cnt - s0), 32'h1);
    check("late_sen_abort",  32'(abort_cnt - a0), 32'h0);
    check("late_sen_tx",     32'(tx_gain), 32'h2b);
    run_frame(16'h0915, rd);
    check("late_sen_next",   32'(rx_gain), 32'h15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ad9866_spi_responder.md
# ad9866_spi_responder

- Synthesizable SPI responder that models the AD9866 serial control port.
- Decodes 16-bit SPI frames from the codec-configuration master and maintains the 20-entry register file (0x00–0x13).
- Returns register contents on reads and exposes decoded gain fields plus a write-event stream.
- Used on the emulation build in place of the physical codec, and as the DUT-side responder in configuration benches.

## Interface
- NUM_REGS, 20: implemented register count; addresses 0..NUM_REGS-1.
- MIN_OVERSAMPLE, 4: minimum clk periods per half sclk period; documentation only, not checked in RTL.

- clk  input  1  system clock; SPI inputs are oversampled in this domain
- reset  input  1  asynchronous, active-high
- sclk  input  1  SPI clock from master, idle low
- sen_n  input  1  SPI frame enable, active low
- sdio  input  1  serial data from master, MSB first
- sdo  output  1  serial read data to master
- sdo_oe  output  1  high while a read data phase is driving sdo
- rx_gain  output  6  register 0x09[5:0]
- tx_gain  output  6  register 0x0a[5:0]
- four_wire  output  1  register 0x00[7]
- wr_strobe  output  1  one-cycle pulse per accepted write
- wr_addr  output  5  address of the last write
- wr_data  output  8  data of the last write
- frame_abort  output  1  one-cycle pulse on a truncated frame

## Operation
- Frame format, MSB first, 16 bits:
  - bit15 = R/W (1 = read)
  - bits14:13 = length, must be 00
  - bits12:8 = address
  - bits7:0 = data
- sdio is sampled on each detected sclk rising edge into a 16-bit shift register. A 5-bit bit counter is cleared whenever sen_n is high.
- States:
  - IDLE → HDR when sen_n falls.
  - HDR, after 8 rising edges → DATA_W if bit15 = 0, DATA_R if bit15 = 1.
  - DATA_W or DATA_R, after 8 more rising edges → DONE.
  - DONE → IDLE when sen_n rises.
  - Any state other than IDLE/DONE → IDLE, with a frame_abort pulse, when sen_n rises early.
- Write commit: in DONE, if address < NUM_REGS and length = 00:
  - register[addr] ← data.
  - wr_strobe pulses; wr_addr and wr_data are updated.
  - Otherwise the write is discarded with no strobe.
- Read: on entry to DATA_R, load an 8-bit read buffer with register[addr], or 0x00 if the address is out of range or length ≠ 00.
  - sdo presents buffer bit7 and shifts on each subsequent detected sclk falling edge.
  - Read value is taken when DATA_R is entered; writes later in the same frame are not reflected.
- sdo_oe = four_wire && state == DATA_R. When sdo_oe is low, sdo = 0.
- Register 0x07 bit0 (DC-offset calibration start) self-clears 16 clk cycles after being written to 1.
- Only one frame is in flight; a new sen_n fall is ignored until the state returns to IDLE.

## Timing
- Reset values:
  - All registers 0x00; four_wire = 0.
  - sdo, sdo_oe, wr_strobe and frame_abort = 0.
  - rx_gain and tx_gain = 0; wr_addr and wr_data = 0.
  - State = IDLE.
- Edge detection runs on registered copies of the inputs. Without sync, detection is 1 clk after the pin edge; with AD9866_SPI_SYNC_EN it is 3 clk.
- Write latency: register, wr_strobe and the gain outputs update 1 clk after the 16th detected rising edge.
- Read: sdo bit7 is valid 1 clk after the 8th detected rising edge; each later bit is valid 1 clk after a detected falling edge.
- Master must hold sclk high or low for ≥ MIN_OVERSAMPLE clk periods.
- Reset asserted mid-frame returns every output and register to its reset value immediately; the frame is lost with no abort pulse.
- sen_n rising in the same clk as the 16th rising edge: the commit completes first, then IDLE; no abort.

## Configuration
- AD9866_SPI_SYNC_EN:
  - Defined: sclk, sen_n and sdio each pass through a 2-flop synchronizer before edge detection, for an asynchronous external master.
  - Undefined: single register stage, for a master in the same clk domain.

## Structure
- Package ad9866_pkg:
  - NUM_REGS, reset-value array, address constants (ADDR_SPI_CFG = 0x00, ADDR_RX_CTRL = 0x07, ADDR_RX_GAIN = 0x09, ADDR_TX_GAIN = 0x0a).
  - State enum.
- Sub-module ad9866_spi_sync: synchronizer or register stage plus rise/fall edge pulses for sclk, and the filtered sen_n level.

## Test plan
- Write frame 0x0080 → wr_strobe with addr 0x00 / data 0x80; four_wire = 1.
- Write 0x0945 then read 0x8900 with four_wire = 1 → rx_gain = 0x05; sdo serializes 0x45; sdo_oe high for exactly 8 bits.
- Read 0x9400 (address 0x14, out of range) → sdo returns 0x00; no wr_strobe.
- sen_n raised after 10 bits of 0x0a3f → frame_abort pulse; tx_gain unchanged at 0.
- Write 0x0721 → register 0x07 = 0x21, reads 0x20 after 16 clk.
- Reset asserted mid-frame of a write 0x0a12 → tx_gain stays 0; the next full frame is decoded correctly.
